// File: rtl/pixel_burst_controller_pkg.sv
// Shared types for the pixel burst engine and the downstream filter:
// RGB pixel layout, FSM/mode encodings and the luma conversion.
package pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ACC = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR_ACC = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RD   = 2'b01,
    MODE_WR   = 2'b10,
    MODE_RW   = 2'b11
  } mode_t;

  // (R + 2G + B) / 4; the 10-bit sum tops out at 1020 so nothing saturates.
  function automatic logic [7:0] luma(input rgb_t px);
    logic [9:0] sum;
    sum = {2'b00, px.r} + {1'b0, px.g, 1'b0} + {2'b00, px.b};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/pixel_burst_controller_if.sv
// Off-chip 24-bit RGB SRAM bus: the controller is master, the memory is slave.
interface pixel_burst_controller_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] address;
  logic [23:0]       w_data;
  logic [23:0]       r_data;
  logic              read_enable;
  logic              write_enable;

  modport master (
    output address, w_data, read_enable, write_enable,
    input  r_data
  );

  modport slave (
    input  address, w_data, read_enable, write_enable,
    output r_data
  );

endinterface

// File: rtl/pixel_burst_controller_rgb_to_gray.sv
// Combinational RGB-to-luma converter, shared with the downstream edge filter.
module rgb_to_gray
  import pixel_pkg::*;
(
  input  rgb_t       pix_i,
  output logic [7:0] gray_o
);

  assign gray_o = luma(pix_i);

endmodule

// File: rtl/pixel_burst_controller.sv
// Burst engine: reads RGB pixels into a packed luma buffer and/or writes
// 8-bit results back as grey RGB words, with SRAM wait states and gap cycles.
module pixel_burst_controller
  import pixel_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 20,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int SRAM_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     rd_base,
  input  logic [ADDR_W-1:0]     wr_base,
  input  logic [CNT_W-1:0]      num_rd,
  input  logic [CNT_W-1:0]      num_wr,
  input  logic [DEPTH-1:0][7:0] data_in,
  output logic [DEPTH-1:0][7:0] data_out,
  output logic                  pix_valid,
  output logic [CNT_W-1:0]      pix_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  pixel_burst_controller_if.master sram
);

  localparam int WAIT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  mode_t             mode_q;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic [CNT_W-1:0]  num_rd_q, num_wr_q;
  logic [DEPTH-1:0][7:0] data_out_q;

  mode_t       mode_in;
  logic        accept;
  logic        wait_last;
  logic [CNT_W-1:0] idx_nxt;
  logic [7:0]  gray;

  assign mode_in   = mode_t'(mode);
  assign accept    = (state_q == ST_IDLE) && start;
  assign wait_last = (wait_q == WAIT_LAST);
  assign idx_nxt   = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = '0;
          wait_d = '0;
          err_d  = 1'b0;
          if ((num_rd > CNT_MAX) || (num_wr > CNT_MAX)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (((mode_in == MODE_RD) || (mode_in == MODE_RW)) && (num_rd != '0)) begin
            state_d = ST_RD_ACC;
          end else if (((mode_in == MODE_WR) || (mode_in == MODE_RW)) && (num_wr != '0)) begin
            state_d = ST_WR_ACC;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_ACC: begin
        wait_d = wait_last ? '0 : wait_q + WAIT_W'(1);
        if (wait_last) state_d = ST_RD_GAP;
      end
      ST_RD_GAP: begin
        if (idx_nxt < num_rd_q) begin
          idx_d   = idx_nxt;
          state_d = ST_RD_ACC;
        end else if ((mode_q == MODE_RW) && (num_wr_q != '0)) begin
          idx_d   = '0;
          state_d = ST_WR_ACC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WR_ACC: begin
        wait_d = wait_last ? '0 : wait_q + WAIT_W'(1);
        if (wait_last) state_d = ST_WR_GAP;
      end
      ST_WR_GAP: begin
        if (idx_nxt < num_wr_q) begin
          idx_d   = idx_nxt;
          state_d = ST_WR_ACC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      // r_data is captured on the edge that ends the last wait cycle
      if ((state_q == ST_RD_ACC) && wait_last) data_out_q[idx_q] <= gray;
    end
  end

  // Request parameters only matter while an access state gates them onto the bus
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q    <= mode_in;
      rd_base_q <= rd_base;
      wr_base_q <= wr_base;
      num_rd_q  <= num_rd;
      num_wr_q  <= num_wr;
    end
  end

  rgb_to_gray u_gray (
    .pix_i  (rgb_t'(sram.r_data)),
    .gray_o (gray)
  );

  assign sram.read_enable  = (state_q == ST_RD_ACC);
  assign sram.write_enable = (state_q == ST_WR_ACC);
  assign sram.address      = (state_q == ST_RD_ACC) ? rd_base_q + ADDR_W'(idx_q) :
                             (state_q == ST_WR_ACC) ? wr_base_q + ADDR_W'(idx_q) : '0;
  assign sram.w_data       = (state_q == ST_WR_ACC) ? {3{data_in[idx_q]}} : '0;

  assign busy      = (state_q == ST_RD_ACC) || (state_q == ST_RD_GAP) ||
                     (state_q == ST_WR_ACC) || (state_q == ST_WR_GAP);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign pix_valid = (state_q == ST_RD_GAP);
  assign pix_idx   = (state_q == ST_RD_GAP) ? idx_q : '0;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_pixel_burst_controller.sv
// Directed bench for pixel_burst_controller with a behavioural SRAM and
// per-cycle bus monitor sampled on the falling clock edge.
module tb_pixel_burst_controller;
  import pixel_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 20;
  localparam int CNT_W  = 5;
  localparam int SRAM_WAIT = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [ADDR_W-1:0] rd_base = '0, wr_base = '0;
  logic [CNT_W-1:0] num_rd = '0, num_wr = '0;
  logic [DEPTH-1:0][7:0] data_in = '0;
  logic [DEPTH-1:0][7:0] data_out;
  logic pix_valid, busy, done, err;
  logic [CNT_W-1:0] pix_idx;

  pixel_burst_controller_if #(.ADDR_W(ADDR_W)) sram ();

  pixel_burst_controller #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .SRAM_WAIT(SRAM_WAIT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .mode(mode),
    .rd_base(rd_base), .wr_base(wr_base), .num_rd(num_rd), .num_wr(num_wr),
    .data_in(data_in), .data_out(data_out), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .busy(busy), .done(done), .err(err), .sram(sram)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sram_rd(input logic [15:0] a);
    case (a)
      16'h0010: return 24'hFF0000;
      16'h0011: return 24'h00FF00;
      16'h0012: return 24'h808080;
      default:  return {3{a[7:0]}};
    endcase
  endfunction

  assign sram.r_data = sram_rd(sram.address);

  logic [23:0] wmem [0:65535];
  always @(posedge clk) if (sram.write_enable) wmem[sram.address] <= sram.w_data;

  int checks = 0, failures = 0;
  int cycle_no = 0, start_cyc = 0;
  int rd_cnt, wr_cnt, both_cnt, turn_cnt, unstable_cnt, busy_cnt, done_cnt, done_cyc;
  logic done_err;
  int pv_cyc[$], pv_idx[$], pv_dat[$], rd_addrs[$], wr_addrs[$];
  logic prev_re = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [23:0] prev_wd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; turn_cnt = 0; unstable_cnt = 0;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; done_err = 1'b0;
    pv_cyc.delete(); pv_idx.delete(); pv_dat.delete();
    rd_addrs.delete(); wr_addrs.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_no++;
    if (pix_valid) begin
      pv_cyc.push_back(cycle_no - start_cyc);
      pv_idx.push_back(int'(pix_idx));
      pv_dat.push_back(int'(data_out[pix_idx]));
    end
    if (sram.read_enable) rd_cnt++;
    if (sram.write_enable) wr_cnt++;
    if (sram.read_enable && sram.write_enable) both_cnt++;
    if ((sram.read_enable && prev_we) || (sram.write_enable && prev_re)) turn_cnt++;
    if (sram.read_enable && !prev_re) rd_addrs.push_back(int'(sram.address));
    if (sram.write_enable && !prev_we) wr_addrs.push_back(int'(sram.address));
    if (((sram.read_enable && prev_re) || (sram.write_enable && prev_we)) &&
        ((sram.address != prev_addr) || (sram.w_data != prev_wd))) unstable_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_cyc = cycle_no - start_cyc;
        done_err = err;
      end
    end
    prev_re = sram.read_enable;
    prev_we = sram.write_enable;
    prev_addr = sram.address;
    prev_wd = sram.w_data;
  endtask

  task automatic start_burst(input logic [1:0] m, input logic [15:0] rb, input logic [15:0] wb,
                             input int nr, input int nw);
    tick();
    mode = m; rd_base = rb; wr_base = wb;
    num_rd = CNT_W'(nr); num_wr = CNT_W'(nw);
    start = 1'b1;
    clear_stats();
    start_cyc = cycle_no;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    clear_stats();
    n_rst = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pixv", pix_valid, 0);
    check("rst_re", sram.read_enable, 0);
    check("rst_we", sram.write_enable, 0);
    check("rst_addr", sram.address, 0);
    check("rst_dout", |data_out, 0);
    n_rst = 1'b1;

    // read three pixels from 0x0010
    start_burst(2'b01, 16'h0010, 16'h0000, 3, 0);
    wait_done(40);
    check("rd_done_cyc", done_cyc, 10);
    check("rd_err", done_err, 0);
    check("rd_pv_n", pv_cyc.size(), 3);
    check("rd_pv_cyc0", pv_cyc[0], 3);
    check("rd_pv_cyc1", pv_cyc[1], 6);
    check("rd_pv_cyc2", pv_cyc[2], 9);
    check("rd_pv_idx1", pv_idx[1], 1);
    check("rd_pv_idx2", pv_idx[2], 2);
    check("rd_pv_dat0", pv_dat[0], 8'h3F);
    check("rd_pv_dat1", pv_dat[1], 8'h7F);
    check("rd_pv_dat2", pv_dat[2], 8'h80);
    check("rd_dout2", data_out[2], 8'h80);
    check("rd_re_cycles", rd_cnt, 6);
    check("rd_we_cycles", wr_cnt, 0);
    check("rd_addr0", rd_addrs[0], 16'h0010);
    check("rd_addr2", rd_addrs[2], 16'h0012);

    // write two grey pixels to 0x0100
    data_in[0] = 8'hBB; data_in[1] = 8'hBF;
    start_burst(2'b10, 16'h0000, 16'h0100, 0, 2);
    wait_done(40);
    check("wr_done_cyc", done_cyc, 7);
    check("wr_mem100", wmem[16'h0100], 24'hBBBBBB);
    check("wr_mem101", wmem[16'h0101], 24'hBFBFBF);
    check("wr_we_cycles", wr_cnt, 4);
    check("wr_re_cycles", rd_cnt, 0);
    check("wr_addr1", wr_addrs[1], 16'h0101);
    check("wr_stable", unstable_cnt, 0);
    check("wr_dout_kept", data_out[0], 8'h3F);

    // full-depth read-then-write across the address wrap
    for (int i = 0; i < DEPTH; i++) data_in[i] = 8'h40 + 8'(i);
    start_burst(2'b11, 16'hFFF8, 16'h0200, 20, 20);
    wait_done(200);
    check("rw_done_cyc", done_cyc, 121);
    check("rw_re_cycles", rd_cnt, 40);
    check("rw_we_cycles", wr_cnt, 40);
    check("rw_both", both_cnt, 0);
    check("rw_turnaround", turn_cnt, 0);
    check("rw_stable", unstable_cnt, 0);
    check("rw_rd_n", rd_addrs.size(), 20);
    check("rw_addr0", rd_addrs[0], 16'hFFF8);
    check("rw_addr7", rd_addrs[7], 16'hFFFF);
    check("rw_addr8", rd_addrs[8], 16'h0000);
    check("rw_addr19", rd_addrs[19], 16'h000B);
    check("rw_waddr0", wr_addrs[0], 16'h0200);
    check("rw_dout0", data_out[0], 8'hF8);
    check("rw_dout8", data_out[8], 8'h00);
    check("rw_dout19", data_out[19], 8'h0B);
    check("rw_mem200", wmem[16'h0200], 24'h404040);
    check("rw_mem213", wmem[16'h0213], 24'h535353);

    // oversize request is rejected
    start_burst(2'b01, 16'h0010, 16'h0000, 21, 0);
    wait_done(10);
    check("rej_done_cyc", done_cyc, 1);
    check("rej_err", done_err, 1);
    check("rej_busy", busy_cnt, 0);
    check("rej_acc", rd_cnt + wr_cnt, 0);
    check("rej_dout0", data_out[0], 8'hF8);
    check("rej_dout19", data_out[19], 8'h0B);

    // reset in cycle 5 of a read burst
    start_burst(2'b01, 16'h0010, 16'h0000, 3, 0);
    repeat (5) tick();
    n_rst = 1'b0;
    tick();
    check("mrst_pv_before", pv_cyc.size(), 1);
    check("mrst_busy", busy, 0);
    check("mrst_pixv", pix_valid, 0);
    check("mrst_re", sram.read_enable, 0);
    check("mrst_addr", sram.address, 0);
    check("mrst_dout", |data_out, 0);
    n_rst = 1'b1;
    clear_stats();
    repeat (5) tick();
    check("mrst_quiet", rd_cnt + busy_cnt + done_cnt, 0);
    start_burst(2'b01, 16'h0011, 16'h0000, 1, 0);
    wait_done(20);
    check("mrst_done_cyc", done_cyc, 4);
    check("mrst_dout0", data_out[0], 8'h7F);
    check("mrst_dout1", data_out[1], 8'h00);

    // start while busy is ignored
    start_burst(2'b01, 16'h0010, 16'h0000, 2, 0);
    tick(); tick();
    mode = 2'b10; num_wr = CNT_W'(1); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30);
    check("ign_done_cyc", done_cyc, 7);
    check("ign_we", wr_cnt, 0);
    check("ign_pv_n", pv_cyc.size(), 2);
    repeat (4) tick();
    check("ign_done_once", done_cnt, 1);

    // read-then-write with nothing to do
    start_burst(2'b11, 16'h0010, 16'h0300, 0, 0);
    wait_done(10);
    check("empty_done_cyc", done_cyc, 1);
    check("empty_err", done_err, 0);
    check("empty_acc", rd_cnt + wr_cnt + busy_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_burst_controller.md
# pixel_burst_controller

Parametrised burst engine between the edge-detector datapath and the off-chip 24-bit RGB SRAM. On `start` it reads up to DEPTH pixels from a base address, converts each to 8-bit luma into a packed output buffer, and/or writes up to DEPTH 8-bit results back as grey RGB words. It replaces the fixed 20-pixel pixelcontroller with configurable depth, SRAM wait states, read/write/read-then-write modes, start/done handshake and error reporting.

## Interface
- ADDR_W, 16, SRAM address width
- DEPTH, 20, buffer entries (max pixels per burst)
- CNT_W, $clog2(DEPTH+1), pixel count width
- SRAM_WAIT, 2, cycles an enable is held per access (>=1)
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request, sampled only when idle
- mode  in  2  00 none, 01 read, 10 write, 11 read-then-write
- rd_base, wr_base  in  ADDR_W each  first read/write address
- num_rd, num_wr  in  CNT_W each  pixels to read/write
- data_in  in  DEPTH*8  packed [DEPTH-1:0][7:0] write pixels, stable while busy
- data_out  out  DEPTH*8  packed luma buffer
- pix_valid  out  1  pulse per captured read pixel (successor of read_now)
- pix_idx  out  CNT_W  index of pixel flagged by pix_valid
- busy, done, err  out  1 each  burst active / completion pulse / request rejected
- address  out  ADDR_W;  w_data  out  24;  r_data  in  24
- read_enable, write_enable  out  1 each  SRAM strobes, never both high

## Operation
- States: IDLE, RD_ACC, RD_GAP, WR_ACC, WR_GAP, DONE.
- IDLE: on start, latch mode, bases, counts. If num_rd>DEPTH or num_wr>DEPTH -> DONE with err. If mode==00 or active-phase counts all zero -> DONE, no access. Else RD_ACC (mode 01/11, num_rd>0) or WR_ACC.
- RD_ACC: address=rd_base+idx (mod 2^ADDR_W), read_enable=1 for SRAM_WAIT cycles; r_data sampled at the edge ending the last cycle; data_out[idx] <= (R + 2G + B) >> 2, 10-bit intermediate, no saturation needed.
- RD_GAP: one cycle, enables low, pix_valid=1, pix_idx=idx; then next pixel, or WR_ACC (mode 11, num_wr>0), or DONE.
- WR_ACC: address=wr_base+idx, w_data={g,g,g} with g=data_in[idx], write_enable=1 for SRAM_WAIT cycles, address/data stable throughout.
- WR_GAP: one cycle, enables low; next pixel or DONE.
- DONE: done=1 (err=1 if rejected) one cycle, busy=0, -> IDLE.
- start outside IDLE ignored. data_out holds until overwritten by a later read or reset; unread entries unchanged.

## Timing
- Reset (n_rst low at an edge): all outputs 0, data_out cleared, state IDLE, effective at that edge even mid-burst; no partial access continues.
- busy=1 from cycle after start edge through the last GAP cycle.
- Per pixel: SRAM_WAIT+1 cycles. Read-only N: done in cycle N*(SRAM_WAIT+1)+1 after start. Mode 11: (num_rd+num_wr)*(SRAM_WAIT+1)+1.
- Rejected/empty request: done (and err if rejected) in cycle 1 after start.
- pix_valid coincides with updated data_out[idx] visible.
- Gap cycle guarantees one bus-idle cycle between any two accesses and on read->write turnaround.

## Structure
- Package pixel_pkg: rgb_t packed struct {r,g,b} 8 bits each, state_t and mode_t enums, luma() function.
- Sub-module rgb_to_gray: combinational rgb_t -> 8-bit luma, reused by the downstream filter.

## Test plan
- Mode 01, rd_base=0x0010, num_rd=3, SRAM 0x10..0x12 = FF0000, 00FF00, 808080 -> data_out[0..2]=3F,7F,80; pix_valid at cycles 3,6,9; done cycle 10.
- Mode 10, wr_base=0x0100, num_wr=2, data_in[0]=BB, [1]=BF -> SRAM 0x100=BBBBBB, 0x101=BFBFBF; write_enable high 2 cycles each; read_enable never high.
- Mode 11, rd_base=0xFFF8, num_rd=20, num_wr=20 -> read addresses FFF8..FFFF,0000..000B; writes follow without overlap; done cycle 121.
- num_rd=21 -> done and err in cycle 1, no enable ever asserted, data_out unchanged.
- n_rst low at cycle 5 of a read burst -> all outputs 0 next edge; new start afterwards completes normally.
- start pulsed while busy -> ignored; mode 11 with num_rd=num_wr=0 -> done cycle 1, no accesses.
